cpu_mem_arbiter: RTL and testbench
==================================

# cpu_mem_arbiter

Shares one unified memory port between the multicycle CPU's instruction-fetch channel and its load/store channel. It sits between the CPU core and the memory/bus wrapper. Requests are granted round-robin, with one outstanding transaction at a time. Grant and conflict counts are exported for the performance-counter bank.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the strobe is `DATA_W/8`.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `inst_req_valid` in 1; `inst_addr` in ADDR_W; `inst_req_ready` out 1: fetch request.
- `inst_rdata` out DATA_W; `inst_valid` out 1; `inst_ready` in 1: fetch response.
- `mem_read` in 1; `mem_write` in 1; `mem_addr` in ADDR_W; `mem_wdata` in DATA_W; `mem_wstrb` in DATA_W/8; `mem_req_ready` out 1: data request.
- `read_data` out DATA_W; `read_data_valid` out 1; `read_data_ready` in 1: load response.
- `m_req_valid` out 1; `m_req_ready` in 1; `m_wen` out 1; `m_addr` out ADDR_W; `m_wdata` out DATA_W; `m_wstrb` out DATA_W/8: downstream request.
- `m_rdata` in DATA_W; `m_resp_valid` in 1; `m_resp_ready` out 1: downstream read response.
- `cnt_inst_grant` out 32; `cnt_data_grant` out 32; `cnt_conflict` out 32: performance counters.

## Operation
- A data request is `mem_read | mem_write`. If both are high, it is a write.
- The FSM has five one-hot states: `S_IDLE`, `S_IREQ`, `S_IRESP`, `S_DREQ`, `S_DRESP`.
- **S_IDLE, single requester:**
  - Only the fetch side is requesting: go to `S_IREQ`.
  - Only the data side is requesting: go to `S_DREQ`.
- **S_IDLE, both requesting:** grant the side not recorded in `last_grant`. Update `last_grant` on every grant.
- **S_IDLE, nothing requesting:** stay in `S_IDLE`.
- **S_IREQ:**
  - Drive `m_req_valid=1`, `m_wen=0`, `m_addr=inst_addr`, and `inst_req_ready=m_req_ready`.
  - When `m_req_valid & m_req_ready`, go to `S_IRESP`.
- **S_DREQ:**
  - Drive `m_req_valid=1`, `m_wen=mem_write`, `m_addr=mem_addr`, `m_wdata=mem_wdata`, and `mem_req_ready=m_req_ready`.
  - `m_wstrb` is `mem_wstrb` for a write and 0 for a read.
  - On handshake, a write goes to `S_IDLE` (writes carry no response phase) and a read goes to `S_DRESP`.
- **S_IRESP:**
  - Drive `inst_valid=m_resp_valid`, `inst_rdata=m_rdata`, and `m_resp_ready=inst_ready`.
  - When `m_resp_valid & inst_ready`, go to `S_IDLE`.
- **S_DRESP:** same as `S_IRESP`, routed to `read_data*` / `read_data_ready`.
- **Forwarding and idle values:**
  - Request fields are forwarded combinationally. Requesters hold them stable until their ready is seen.
  - Every ready and valid not listed for the current state is 0.
  - `m_addr`, `m_wdata`, `m_wstrb` and both rdata outputs are 0 outside their active states.
- **Counters:**
  - `cnt_inst_grant` increments on each `S_IDLE→S_IREQ` transition.
  - `cnt_data_grant` increments on each `S_IDLE→S_DREQ` transition.
  - `cnt_conflict` increments on each `S_IDLE` cycle where both sides request.
  - All counters wrap modulo 2^32.
- **Unsolicited responses:** an `m_resp_valid` seen outside the RESP states is ignored (`m_resp_ready=0`).

## Timing
- **Reset:** `rst` takes effect on the next `posedge clk` from any state, including mid-transaction.
  - Forces `S_IDLE` and `last_grant=DATA`, so the first conflict goes to fetch.
  - Clears all counters.
  - All outputs are 0 in the reset cycle and after it.
- **Grant latency:** a request first visible in `S_IDLE` at cycle N gives `m_req_valid=1` at N+1. There is no combinational path from a requester valid to `m_req_valid` while in `S_IDLE`.
- **Request phase:** `m_req_valid` stays high until the handshake. The accepting edge moves the FSM, so `m_req_valid` is 0 in the next cycle unless that cycle is a RESP state, where it stays 0.
- **Minimum cycles:**
  - Read transaction (fetch or load): 3, i.e. IDLE, REQ, RESP with immediate readies.
  - Write: 2.
- **Back-to-back traffic:** after a response handshake, the next grant is decided in the following `S_IDLE` cycle. There is no same-cycle re-grant.
- **Withdrawn requests:** a requester dropping its valid while in REQ is a protocol violation. The arbiter keeps driving until the handshake.

## Structure
- Shared package `cpu_mem_pkg` holds:
  - the state one-hot localparams;
  - `GRANT_INST=1'b0` and `GRANT_DATA=1'b1`.
- One sub-module, `rr_arb2`: a two-input round-robin pick with a `last_grant` register and an `update` enable.
- The FSM, muxing and counters live in `cpu_mem_arbiter`.

## Test plan
- **Lone fetch:** `inst_req_valid=1`, `inst_addr=0x100`, memory ready with zero wait, `m_rdata=0x2402000A`.
  - Expect `m_addr=0x100` at cycle 1 and `inst_valid` with `0x2402000A` at cycle 2.
  - Expect `cnt_inst_grant=1`.
- **Conflict alternation:** fetch and load both pending from reset, each re-requesting after completion, for 4 transactions.
  - Expect grant order I, D, I, D.
  - Expect `cnt_conflict=4`, `cnt_inst_grant=2`, `cnt_data_grant=2`.
- **Store:** `mem_write=1`, `mem_addr=0x204`, `mem_wstrb=4'b0010`, `m_req_ready` low for 3 cycles.
  - Expect `m_req_valid` held 3 cycles with stable fields, then accept.
  - Expect return to `S_IDLE` without `read_data_valid`.
- **Load with stall:** `m_resp_valid` arrives while `read_data_ready=0` for 2 cycles.
  - Expect `m_resp_ready=0` and `read_data_valid=1` held.
  - Expect completion in the cycle ready rises.
- **Reset mid-read:** assert `rst` in `S_IRESP`.
  - Expect all valids and readies 0 the next cycle, counters 0, and a following conflict granted to fetch.
- **Simultaneous read and write:** `mem_read=mem_write=1` gives `m_wen=1` and no response phase.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory-port arbiter: one-hot FSM states and grant encoding.
package cpu_mem_pkg;

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_IREQ  = 5'b00010,
        S_IRESP = 5'b00100,
        S_DREQ  = 5'b01000,
        S_DRESP = 5'b10000
    } state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle between CPU fetch/load-store channels, the arbiter and the memory wrapper.
// master: arbiter view; slave: the surrounding CPU core and memory wrapper.
interface cpu_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              inst_req_valid;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_req_ready;
    logic [DATA_W-1:0] inst_rdata;
    logic              inst_valid;
    logic              inst_ready;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [STRB_W-1:0] mem_wstrb;
    logic              mem_req_ready;
    logic [DATA_W-1:0] read_data;
    logic              read_data_valid;
    logic              read_data_ready;

    logic              m_req_valid;
    logic              m_req_ready;
    logic              m_wen;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic [DATA_W-1:0] m_rdata;
    logic              m_resp_valid;
    logic              m_resp_ready;

    modport master (
        input  inst_req_valid, inst_addr, inst_ready,
        input  mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, read_data_ready,
        input  m_req_ready, m_rdata, m_resp_valid,
        output inst_req_ready, inst_rdata, inst_valid,
        output mem_req_ready, read_data, read_data_valid,
        output m_req_valid, m_wen, m_addr, m_wdata, m_wstrb, m_resp_ready
    );

    modport slave (
        output inst_req_valid, inst_addr, inst_ready,
        output mem_read, mem_write, mem_addr, mem_wdata, mem_wstrb, read_data_ready,
        output m_req_ready, m_rdata, m_resp_valid,
        input  inst_req_ready, inst_rdata, inst_valid,
        input  mem_req_ready, read_data, read_data_valid,
        input  m_req_valid, m_wen, m_addr, m_wdata, m_wstrb, m_resp_ready
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin pick; on a conflict the side not granted last time wins.
module rr_arb2
    import cpu_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_inst,
    input  logic req_data,
    input  logic update,
    output logic grant
);

    logic last_grant_q;

    // Reset to DATA so the first conflict after reset goes to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= GRANT_DATA;
        end else if (update) begin
            last_grant_q <= grant;
        end
    end

    always_comb begin
        grant = GRANT_INST;
        if (req_inst && req_data) begin
            grant = (last_grant_q == GRANT_DATA) ? GRANT_INST : GRANT_DATA;
        end else if (req_data) begin
            grant = GRANT_DATA;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with round-robin grant and performance counters.
module cpu_mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    cpu_mem_arbiter_if.master   bus,
    output logic [31:0]         cnt_inst_grant,
    output logic [31:0]         cnt_data_grant,
    output logic [31:0]         cnt_conflict
);

    localparam int unsigned STRB_W = DATA_W / 8;

    state_e            state_q, state_d;
    logic              inst_req, data_req, idle, arb_update, grant;
    logic [ADDR_W-1:0] req_addr;
    logic [STRB_W-1:0] wstrb_sel;
    logic [31:0]       cnt_inst_q, cnt_data_q, cnt_conflict_q;

    assign inst_req   = bus.inst_req_valid;
    assign data_req   = bus.mem_read | bus.mem_write;
    assign idle       = (state_q == S_IDLE);
    assign arb_update = idle & (inst_req | data_req);
    assign req_addr   = (state_q == S_DREQ) ? bus.mem_addr : bus.inst_addr;
    assign wstrb_sel  = bus.mem_write ? bus.mem_wstrb : '0;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .rst      (rst),
        .req_inst (inst_req),
        .req_data (data_req),
        .update   (arb_update),
        .grant    (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            cnt_inst_q     <= '0;
            cnt_data_q     <= '0;
            cnt_conflict_q <= '0;
        end else begin
            state_q <= state_d;
            if (idle && inst_req && data_req) cnt_conflict_q <= cnt_conflict_q + 32'd1;
            if (arb_update && grant == GRANT_INST) cnt_inst_q <= cnt_inst_q + 32'd1;
            if (arb_update && grant == GRANT_DATA) cnt_data_q <= cnt_data_q + 32'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (inst_req || data_req) state_d = (grant == GRANT_INST) ? S_IREQ : S_DREQ;
            end
            S_IREQ:  if (bus.m_req_ready) state_d = S_IRESP;
            // Writes have no response phase.
            S_DREQ:  if (bus.m_req_ready) state_d = bus.mem_write ? S_IDLE : S_DRESP;
            S_IRESP: if (bus.m_resp_valid && bus.inst_ready) state_d = S_IDLE;
            S_DRESP: if (bus.m_resp_valid && bus.read_data_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are forced to zero while rst is high, even before the reset edge lands.
    always_comb begin
        bus.inst_req_ready  = 1'b0;
        bus.inst_valid      = 1'b0;
        bus.inst_rdata      = '0;
        bus.mem_req_ready   = 1'b0;
        bus.read_data_valid = 1'b0;
        bus.read_data       = '0;
        bus.m_req_valid     = 1'b0;
        bus.m_wen           = 1'b0;
        bus.m_addr          = '0;
        bus.m_wdata         = '0;
        bus.m_wstrb         = '0;
        bus.m_resp_ready    = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_IREQ: begin
                    bus.m_req_valid    = 1'b1;
                    bus.m_addr         = req_addr;
                    bus.inst_req_ready = bus.m_req_ready;
                end
                S_DREQ: begin
                    bus.m_req_valid   = 1'b1;
                    bus.m_wen         = bus.mem_write;
                    bus.m_addr        = req_addr;
                    bus.m_wdata       = bus.mem_wdata;
                    bus.m_wstrb       = wstrb_sel;
                    bus.mem_req_ready = bus.m_req_ready;
                end
                S_IRESP: begin
                    bus.inst_valid   = bus.m_resp_valid;
                    bus.inst_rdata   = bus.m_rdata;
                    bus.m_resp_ready = bus.inst_ready;
                end
                S_DRESP: begin
                    bus.read_data_valid = bus.m_resp_valid;
                    bus.read_data       = bus.m_rdata;
                    bus.m_resp_ready    = bus.read_data_ready;
                end
                default: ;
            endcase
        end
    end

    assign cnt_inst_grant = rst ? '0 : cnt_inst_q;
    assign cnt_data_grant = rst ? '0 : cnt_data_q;
    assign cnt_conflict   = rst ? '0 : cnt_conflict_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Bench for cpu_mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-owner reference model.
module tb_cpu_mem_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] cnt_inst_grant, cnt_data_grant, cnt_conflict;

    cpu_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .cnt_inst_grant (cnt_inst_grant),
        .cnt_data_grant (cnt_data_grant),
        .cnt_conflict   (cnt_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns the port (0 none, 1 fetch, 2 data), whether it awaits a response.
    int          own;
    bit          in_resp;
    bit          last_was_data;
    int unsigned exp_ci, exp_cd, exp_cc;
    bit          inst_acc, data_acc;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Compare every DUT output with what the model says for the current inputs.
    task automatic settle();
        logic        e_req, e_wen, e_irr, e_mrr, e_mrr_resp, e_iv, e_dv;
        logic [31:0] e_addr, e_wdata, e_ird, e_rd;
        logic [3:0]  e_strb;
        #1;
        {e_req, e_wen, e_irr, e_mrr, e_mrr_resp, e_iv, e_dv} = '0;
        {e_addr, e_wdata, e_ird, e_rd} = '0;
        e_strb = '0;
        if (!rst && own == 1 && !in_resp) begin
            e_req  = 1'b1;
            e_addr = bus.inst_addr;
            e_irr  = bus.m_req_ready;
        end else if (!rst && own == 1) begin
            e_iv       = bus.m_resp_valid;
            e_ird      = bus.m_rdata;
            e_mrr_resp = bus.inst_ready;
        end else if (!rst && own == 2 && !in_resp) begin
            e_req   = 1'b1;
            e_wen   = bus.mem_write;
            e_addr  = bus.mem_addr;
            e_wdata = bus.mem_wdata;
            e_strb  = bus.mem_write ? bus.mem_wstrb : 4'h0;
            e_mrr   = bus.m_req_ready;
        end else if (!rst && own == 2) begin
            e_dv       = bus.m_resp_valid;
            e_rd       = bus.m_rdata;
            e_mrr_resp = bus.read_data_ready;
        end
        check_value("handshakes",
                    32'({bus.m_req_valid, bus.m_wen, bus.inst_req_ready, bus.mem_req_ready,
                         bus.m_resp_ready, bus.inst_valid, bus.read_data_valid}),
                    32'({e_req, e_wen, e_irr, e_mrr, e_mrr_resp, e_iv, e_dv}));
        check_value("m_addr", bus.m_addr, e_addr);
        check_value("m_wdata", bus.m_wdata, e_wdata);
        check_value("m_wstrb", 32'(bus.m_wstrb), 32'(e_strb));
        check_value("inst_rdata", bus.inst_rdata, e_ird);
        check_value("read_data", bus.read_data, e_rd);
        check_value("cnt_inst_grant", cnt_inst_grant, rst ? 32'd0 : exp_ci);
        check_value("cnt_data_grant", cnt_data_grant, rst ? 32'd0 : exp_cd);
        check_value("cnt_conflict", cnt_conflict, rst ? 32'd0 : exp_cc);
    endtask

    // Apply the arbitration rules to the inputs present at the coming clock edge.
    task automatic advance();
        bit ir, dr, pick_data;
        inst_acc = !rst && own == 1 && !in_resp && bus.m_req_ready;
        data_acc = !rst && own == 2 && !in_resp && bus.m_req_ready;
        if (rst) begin
            own = 0; in_resp = 0; last_was_data = 1;
            exp_ci = 0; exp_cd = 0; exp_cc = 0;
        end else if (own == 0) begin
            ir = bus.inst_req_valid;
            dr = bus.mem_read | bus.mem_write;
            if (ir && dr) exp_cc++;
            if (ir || dr) begin
                pick_data = (ir && dr) ? !last_was_data : dr;
                last_was_data = pick_data;
                own = pick_data ? 2 : 1;
                in_resp = 0;
                if (pick_data) exp_cd++;
                else exp_ci++;
            end
        end else if (!in_resp) begin
            if (bus.m_req_ready) begin
                if (own == 2 && bus.mem_write) own = 0;
                else in_resp = 1;
            end
        end else if (bus.m_resp_valid && ((own == 1) ? bus.inst_ready : bus.read_data_ready)) begin
            own = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        advance();
    endtask

    task automatic idle_inputs();
        bus.inst_req_valid  = 0; bus.inst_addr = '0; bus.inst_ready = 0;
        bus.mem_read        = 0; bus.mem_write = 0; bus.mem_addr = '0;
        bus.mem_wdata       = '0; bus.mem_wstrb = '0; bus.read_data_ready = 0;
        bus.m_req_ready     = 0; bus.m_rdata = '0; bus.m_resp_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        idle_inputs();
        cycle();
        rst = 0;
    endtask

    logic [31:0] order[$];
    logic [31:0] exp_order[4];
    logic [31:0] got;

    initial begin
        own = 0; in_resp = 0; last_was_data = 1;
        exp_ci = 0; exp_cd = 0; exp_cc = 0;
        inst_acc = 0; data_acc = 0;

        // Lone fetch with zero-wait memory.
        do_reset();
        check_value("reset_cnt_inst", cnt_inst_grant, 32'd0);
        bus.inst_req_valid = 1; bus.inst_addr = 32'h100; bus.m_req_ready = 1;
        bus.m_resp_valid = 1; bus.m_rdata = 32'h2402000A; bus.inst_ready = 1;
        settle(); check_value("lone_c0_req", 32'(bus.m_req_valid), 32'd0); advance();
        settle(); check_value("lone_c1_addr", bus.m_addr, 32'h100);
        check_value("lone_c1_req", 32'(bus.m_req_valid), 32'd1); advance();
        bus.inst_req_valid = 0;
        settle(); check_value("lone_c2_ivalid", 32'(bus.inst_valid), 32'd1);
        check_value("lone_c2_rdata", bus.inst_rdata, 32'h2402000A); advance();
        settle(); check_value("lone_cnt", cnt_inst_grant, 32'd1); advance();

        // Conflict alternation: both sides keep requesting.
        do_reset();
        bus.inst_req_valid = 1; bus.inst_addr = 32'h40;
        bus.mem_read = 1; bus.mem_addr = 32'h80;
        bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.inst_ready = 1; bus.read_data_ready = 1;
        order.delete();
        repeat (12) begin
            settle();
            if (bus.m_req_valid && bus.m_req_ready) order.push_back(bus.m_addr);
            advance();
        end
        settle();
        check_value("alt_cnt_conflict", cnt_conflict, 32'd4);
        check_value("alt_cnt_inst", cnt_inst_grant, 32'd2);
        check_value("alt_cnt_data", cnt_data_grant, 32'd2);
        check_value("alt_order_len", 32'(order.size()), 32'd4);
        exp_order[0] = 32'h40; exp_order[1] = 32'h80; exp_order[2] = 32'h40; exp_order[3] = 32'h80;
        for (int i = 0; i < 4; i++) begin
            got = (i < order.size()) ? order[i] : 32'hFFFF_FFFF;
            check_value("alt_order", got, exp_order[i]);
        end
        advance();

        // Store held off by memory for three cycles; stray response valid must be ignored.
        do_reset();
        bus.mem_write = 1; bus.mem_addr = 32'h204; bus.mem_wstrb = 4'b0010;
        bus.mem_wdata = 32'hCAFEF00D; bus.m_resp_valid = 1; bus.read_data_ready = 1;
        cycle();
        repeat (3) begin
            settle();
            check_value("st_hold_valid", 32'(bus.m_req_valid), 32'd1);
            check_value("st_addr", bus.m_addr, 32'h204);
            check_value("st_wstrb", 32'(bus.m_wstrb), 32'h2);
            check_value("st_wdata", bus.m_wdata, 32'hCAFEF00D);
            advance();
        end
        bus.m_req_ready = 1;
        settle(); check_value("st_accept", 32'(bus.mem_req_ready), 32'd1); advance();
        bus.mem_write = 0;
        settle(); check_value("st_no_rvalid", 32'(bus.read_data_valid), 32'd0);
        check_value("st_idle_req", 32'(bus.m_req_valid), 32'd0); advance();

        // Load whose response is stalled by the consumer.
        do_reset();
        bus.mem_read = 1; bus.mem_addr = 32'h300; bus.mem_wstrb = 4'hF; bus.m_req_ready = 1;
        bus.m_resp_valid = 1; bus.m_rdata = 32'h12345678;
        cycle();
        settle(); check_value("ld_wstrb_read", 32'(bus.m_wstrb), 32'd0); advance();
        bus.mem_read = 0;
        repeat (2) begin
            settle();
            check_value("ld_stall_mrr", 32'(bus.m_resp_ready), 32'd0);
            check_value("ld_stall_valid", 32'(bus.read_data_valid), 32'd1);
            check_value("ld_data", bus.read_data, 32'h12345678);
            advance();
        end
        bus.read_data_ready = 1;
        settle(); check_value("ld_done_mrr", 32'(bus.m_resp_ready), 32'd1); advance();
        settle(); check_value("ld_back_idle", 32'(bus.read_data_valid), 32'd0); advance();

        // Reset while a fetch waits for its response.
        do_reset();
        bus.inst_req_valid = 1; bus.inst_addr = 32'h500; bus.m_req_ready = 1; bus.inst_ready = 1;
        cycle(); cycle();
        bus.inst_req_valid = 0;
        settle(); check_value("rmr_in_iresp", 32'(bus.m_resp_ready), 32'd1); advance();
        rst = 1;
        settle(); check_value("rmr_rst_cycle", 32'(bus.m_resp_ready), 32'd0); advance();
        rst = 0;
        bus.inst_req_valid = 1; bus.inst_addr = 32'h600; bus.mem_read = 1; bus.mem_addr = 32'h700;
        bus.m_resp_valid = 1;
        settle();
        check_value("rmr_after_outs",
                    32'({bus.m_req_valid, bus.inst_valid, bus.m_resp_ready}), 32'd0);
        check_value("rmr_cnt_inst", cnt_inst_grant, 32'd0);
        advance();
        settle(); check_value("rmr_first_grant", bus.m_addr, 32'h600);
        check_value("rmr_cnt_conf", cnt_conflict, 32'd1); advance();

        // Read and write together is a write with no response phase.
        do_reset();
        bus.mem_read = 1; bus.mem_write = 1; bus.mem_addr = 32'h800; bus.mem_wdata = 32'h55AA;
        bus.mem_wstrb = 4'hF; bus.m_req_ready = 1; bus.m_resp_valid = 1; bus.read_data_ready = 1;
        cycle();
        settle(); check_value("rw_wen", 32'(bus.m_wen), 32'd1);
        check_value("rw_wstrb", 32'(bus.m_wstrb), 32'hF); advance();
        bus.mem_read = 0; bus.mem_write = 0;
        settle(); check_value("rw_no_resp", 32'(bus.read_data_valid), 32'd0);
        check_value("rw_mrr", 32'(bus.m_resp_ready), 32'd0); advance();

        // Random traffic; requesters hold their request until accepted.
        do_reset();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (!bus.inst_req_valid || inst_acc) begin
                bus.inst_req_valid = ($urandom_range(0, 2) == 0);
                bus.inst_addr      = $urandom & 32'hFFFF_FFFC;
            end
            if (!(bus.mem_read || bus.mem_write) || data_acc) begin
                case ($urandom_range(0, 5))
                    0:       {bus.mem_read, bus.mem_write} = 2'b10;
                    1:       {bus.mem_read, bus.mem_write} = 2'b01;
                    2:       {bus.mem_read, bus.mem_write} = 2'b11;
                    default: {bus.mem_read, bus.mem_write} = 2'b00;
                endcase
                bus.mem_addr  = $urandom & 32'hFFFF_FFFC;
                bus.mem_wdata = $urandom;
                bus.mem_wstrb = 4'($urandom);
            end
            bus.inst_ready      = ($urandom_range(0, 3) != 0);
            bus.read_data_ready = ($urandom_range(0, 3) != 0);
            bus.m_req_ready     = ($urandom_range(0, 2) != 0);
            bus.m_resp_valid    = ($urandom_range(0, 1) != 0);
            bus.m_rdata         = $urandom;
            rst                 = ($urandom_range(0, 299) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
